// File: rtl/stream_nasti_mover_sched.sv
// Round-robin scheduler sharing one stream_nasti_mover between NUM_REQ producers:
// arbitrates destination requests, issues r_dest/r_valid, routes the granted stream, pulses done.
module stream_nasti_mover_sched #(
   parameter int unsigned NUM_REQ    = 2,
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned DATA_WIDTH = 64
) (
   input  logic                            aclk,
   input  logic                            aresetn,
   input  logic [NUM_REQ-1:0]              req_valid,
   output logic [NUM_REQ-1:0]              req_ready,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
   output logic [NUM_REQ-1:0]              done,
   output logic                            done_err,
   input  logic [NUM_REQ-1:0]              s_t_valid,
   output logic [NUM_REQ-1:0]              s_t_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   s_t_data,
   input  logic [NUM_REQ*DATA_WIDTH/8-1:0] s_t_strb,
   input  logic [NUM_REQ*DATA_WIDTH/8-1:0] s_t_keep,
   input  logic [NUM_REQ-1:0]              s_t_last,
   output logic                            m_t_valid,
   input  logic                            m_t_ready,
   output logic [DATA_WIDTH-1:0]           m_t_data,
   output logic [DATA_WIDTH/8-1:0]         m_t_strb,
   output logic [DATA_WIDTH/8-1:0]         m_t_keep,
   output logic                            m_t_last,
   output logic [ADDR_WIDTH-1:0]           m_r_dest,
   output logic                            m_r_valid,
   input  logic                            m_r_ready,
   output logic                            busy
);

   localparam int unsigned GW = $clog2(NUM_REQ);
   localparam int unsigned SW = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(SW - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [GW-1:0]         grant_q, grant_d;
   logic [GW-1:0]         rr_ptr_q, rr_ptr_d;
   logic [ADDR_WIDTH-1:0] dest_q, dest_d;
   logic                  rvalid_q, rvalid_d;
   logic                  busy_q, busy_d;
   logic                  err_q, err_d;
   logic                  rdy_q;

   logic [GW-1:0]         pick, cand;
   logic                  found;
   logic [ADDR_WIDTH-1:0] pick_addr;
   logic [NUM_REQ-1:0]    req_ready_c;
   logic                  routing;

   always_comb begin
      pick  = '0;
      cand  = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = GW'((32'(rr_ptr_q) + i) % NUM_REQ);
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   assign pick_addr = req_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rr_ptr_d    = rr_ptr_q;
      dest_d      = dest_q;
      rvalid_d    = rvalid_q;
      busy_d      = busy_q;
      err_d       = err_q;
      req_ready_c = '0;
      unique case (state_q)
         S_IDLE: begin
            if (found) begin
               req_ready_c[pick] = 1'b1;
               grant_d           = pick;
               if (|(pick_addr & ALIGN_MASK)) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  err_d    = 1'b0;
                  dest_d   = pick_addr;
                  rvalid_d = 1'b1;
                  busy_d   = 1'b1;
                  state_d  = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            if (m_r_ready) begin
               rvalid_d = 1'b0;
               state_d  = S_BUSY;
            end
         end
         S_BUSY: begin
            if (rdy_q) begin
               err_d   = 1'b0;
               busy_d  = 1'b0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            rr_ptr_d = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q  <= S_IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         dest_q   <= '0;
         rvalid_q <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
         rdy_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         dest_q   <= dest_d;
         rvalid_q <= rvalid_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
         // Sampled only while BUSY so the r_ready of the issue handshake is never taken as completion.
         rdy_q    <= (state_q == S_BUSY) && m_r_ready;
      end
   end

   assign routing = (state_q == S_ISSUE) || (state_q == S_BUSY);

   always_comb begin
      m_t_valid = 1'b0;
      m_t_data  = '0;
      m_t_strb  = '0;
      m_t_keep  = '0;
      m_t_last  = 1'b0;
      s_t_ready = '0;
      if (routing) begin
         m_t_valid          = s_t_valid[grant_q];
         m_t_data           = s_t_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
         m_t_strb           = s_t_strb[grant_q*SW +: SW];
         m_t_keep           = s_t_keep[grant_q*SW +: SW];
         m_t_last           = s_t_last[grant_q];
         s_t_ready[grant_q] = m_t_ready;
      end
   end

   always_comb begin
      done = '0;
      if (state_q == S_DONE) done[grant_q] = 1'b1;
   end

   assign done_err  = (state_q == S_DONE) && err_q;
   assign req_ready = aresetn ? req_ready_c : '0;
   assign m_r_dest  = dest_q;
   assign m_r_valid = rvalid_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_stream_nasti_mover_sched.sv
// Directed bench for stream_nasti_mover_sched: the bench plays both producers and the mover.
module tb_stream_nasti_mover_sched;

   localparam int unsigned NR = 2;
   localparam int unsigned AW = 64;
   localparam int unsigned DW = 64;
   localparam int unsigned SW = DW / 8;

   logic                 aclk = 1'b0;
   logic                 aresetn;
   logic [NR-1:0]        req_valid;
   logic [NR-1:0]        req_ready;
   logic [NR*AW-1:0]     req_addr;
   logic [NR-1:0]        done;
   logic                 done_err;
   logic [NR-1:0]        s_t_valid;
   logic [NR-1:0]        s_t_ready;
   logic [NR*DW-1:0]     s_t_data;
   logic [NR*SW-1:0]     s_t_strb;
   logic [NR*SW-1:0]     s_t_keep;
   logic [NR-1:0]        s_t_last;
   logic                 m_t_valid;
   logic                 m_t_ready;
   logic [DW-1:0]        m_t_data;
   logic [SW-1:0]        m_t_strb;
   logic [SW-1:0]        m_t_keep;
   logic                 m_t_last;
   logic [AW-1:0]        m_r_dest;
   logic                 m_r_valid;
   logic                 m_r_ready;
   logic                 busy;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   stream_nasti_mover_sched #(
      .NUM_REQ   (NR),
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW)
   ) dut (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_addr (req_addr),
      .done     (done),
      .done_err (done_err),
      .s_t_valid(s_t_valid),
      .s_t_ready(s_t_ready),
      .s_t_data (s_t_data),
      .s_t_strb (s_t_strb),
      .s_t_keep (s_t_keep),
      .s_t_last (s_t_last),
      .m_t_valid(m_t_valid),
      .m_t_ready(m_t_ready),
      .m_t_data (m_t_data),
      .m_t_strb (m_t_strb),
      .m_t_keep (m_t_keep),
      .m_t_last (m_t_last),
      .m_r_dest (m_r_dest),
      .m_r_valid(m_r_valid),
      .m_r_ready(m_r_ready),
      .busy     (busy)
   );

   always #5 aclk = ~aclk;

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [63:0] beat(input int unsigned g, input int unsigned k);
      return {8'hD0, 8'(g), 32'h0, 16'(k)};
   endfunction

   // One complete transfer expected to be granted to requester g; the mover is modelled inline.
   task automatic xfer(input int unsigned g, input logic [63:0] addr,
                       input int unsigned nbeats, input logic [7:0] keep);
      logic [NR-1:0] oh;
      oh = NR'(1) << g;
      req_addr[g*AW +: AW] = addr;
      req_valid[g] = 1'b1;
      #1;
      chk("grant_req_ready", req_ready, oh);
      tick();
      req_valid[g] = 1'b0;
      chk("issue_r_valid", m_r_valid, 1);
      chk("issue_r_dest", m_r_dest, addr);
      chk("issue_busy", busy, 1);
      tick();
      m_r_ready = 1'b0;
      chk("busy_r_valid_low", m_r_valid, 0);
      chk("busy_no_req_ready", req_ready, 0);
      for (int unsigned k = 0; k < nbeats; k++) begin
         s_t_valid = '1;
         for (int unsigned j = 0; j < NR; j++) begin
            s_t_data[j*DW +: DW] = beat(j, k);
            s_t_keep[j*SW +: SW] = keep;
            s_t_strb[j*SW +: SW] = keep;
         end
         s_t_last    = '0;
         s_t_last[g] = (k == nbeats - 1);
         #1;
         chk("beat_data", m_t_data, beat(g, k));
         chk("beat_valid_last", {m_t_valid, m_t_last}, {1'b1, (k == nbeats - 1)});
         chk("beat_keep", m_t_keep, keep);
         chk("beat_s_t_ready", s_t_ready, oh);
         tick();
      end
      s_t_valid = '0;
      s_t_last  = '0;
      m_r_ready = 1'b1;
      #1;
      chk("no_early_done0", done, 0);
      tick();
      chk("no_early_done1", done, 0);
      tick();
      chk("done_pulse", done, oh);
      chk("done_err_ok", done_err, 0);
      chk("done_busy_low", busy, 0);
      chk("done_stream_idle", {m_t_valid, s_t_ready}, 0);
      tick();
      chk("done_single", done, 0);
   endtask

   initial begin
      aresetn   = 1'b0;
      req_valid = '0;
      req_addr  = '0;
      s_t_valid = '0;
      s_t_data  = '0;
      s_t_strb  = '0;
      s_t_keep  = '0;
      s_t_last  = '0;
      m_t_ready = 1'b1;
      m_r_ready = 1'b1;
      #2;
      chk("rst_r_valid_dest", {m_r_valid, m_r_dest}, 0);
      chk("rst_ready_done", {req_ready, done, done_err, busy}, 0);
      chk("rst_stream", {m_t_valid, s_t_ready}, 0);
      tick();
      tick();
      aresetn = 1'b1;
      tick();

      // Single request, 8 beats on requester 0
      xfer(0, 64'h1000, 8, 8'hFF);

      // Null packet on requester 1 (rr_ptr returns to 0)
      xfer(1, 64'h1100, 1, 8'h00);

      // Contention: both valid, grants alternate 0,1,0,1
      req_valid = 2'b11;
      xfer(0, 64'h2000, 2, 8'hFF);
      xfer(1, 64'h2100, 2, 8'hFF);
      req_valid = 2'b11;
      xfer(0, 64'h2200, 2, 8'hFF);
      xfer(1, 64'h2300, 2, 8'hFF);
      req_valid = '0;

      // Misaligned request on requester 1
      req_addr[1*AW +: AW] = 64'h1004;
      req_valid = 2'b10;
      s_t_valid = 2'b10;
      s_t_data[1*DW +: DW] = 64'hFFFF_0000_1234_5678;
      #1;
      chk("mis_req_ready", req_ready, 2'b10);
      tick();
      req_valid = '0;
      chk("mis_done", {done, done_err}, {2'b10, 1'b1});
      chk("mis_no_issue", {m_r_valid, busy}, 0);
      chk("mis_stream_idle", {m_t_valid, m_t_data, s_t_ready}, 0);
      tick();
      chk("mis_done_single", {done, done_err}, 0);
      s_t_valid = '0;

      // Mover stall in ISSUE for 20 cycles, requester 0
      req_addr[0*AW +: AW] = 64'h3000;
      req_valid = 2'b01;
      m_r_ready = 1'b0;
      #1;
      chk("stall_req_ready", req_ready, 2'b01);
      tick();
      req_valid = '0;
      for (int unsigned c = 0; c < 20; c++) begin
         chk("stall_hold", {m_r_valid, busy, done, m_r_dest}, {1'b1, 1'b1, 2'b00, 64'h3000});
         tick();
      end
      m_r_ready = 1'b1;
      tick();
      m_r_ready = 1'b0;
      chk("stall_released", m_r_valid, 0);
      s_t_valid = 2'b01;
      s_t_last  = 2'b01;
      s_t_data[0*DW +: DW] = 64'h5555;
      #1;
      chk("stall_beat", m_t_data, 64'h5555);
      tick();
      s_t_valid = '0;
      s_t_last  = '0;
      m_r_ready = 1'b1;
      tick();
      tick();
      chk("stall_done", {done, done_err}, {2'b01, 1'b0});
      tick();

      // Reset during beat 3 of a requester-1 transfer
      req_addr[1*AW +: AW] = 64'h4000;
      req_valid = 2'b10;
      #1;
      chk("rb_req_ready", req_ready, 2'b10);
      tick();
      req_valid = '0;
      tick();
      m_r_ready = 1'b0;
      for (int unsigned k = 0; k < 3; k++) begin
         s_t_valid = 2'b10;
         s_t_data[1*DW +: DW] = beat(1, k);
         if (k < 2) tick();
      end
      #1;
      chk("rb_beat3", {m_t_valid, m_t_data}, {1'b1, beat(1, 2)});
      aresetn = 1'b0;
      #1;
      chk("rb_rst_r", {m_r_valid, m_r_dest}, 0);
      chk("rb_rst_outs", {req_ready, done, done_err, busy}, 0);
      chk("rb_rst_stream", {m_t_valid, m_t_data, s_t_ready}, 0);
      s_t_valid = '0;
      tick();
      tick();
      aresetn   = 1'b1;
      m_r_ready = 1'b1;
      tick();
      chk("rb_no_done", {done, busy}, 0);
      req_addr[1*AW +: AW] = 64'h5000;
      req_valid = 2'b11;
      xfer(0, 64'h6000, 2, 8'h0F);
      req_valid = '0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
